// File: rtl/toggle_rx_pkg.sv
// Shared defaults and types for the toggle-event receiver.
// Optional glitch filter is selected with TOGGLE_EVENT_RX_GLITCH_FILTER_EN.
package toggle_rx_pkg;

  localparam int TOGGLE_RX_SYNC_DEF  = 2;
  localparam int TOGGLE_RX_CNT_W_DEF = 4;

  typedef logic [TOGGLE_RX_CNT_W_DEF-1:0] pending_t;

endpackage

// File: rtl/toggle_event_rx_sync_chain.sv
// Single-bit synchroniser flop chain with synchronous active-high reset to 0.
// Reusable for any single-bit clock-domain crossing.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/toggle_event_rx.sv
// Receive side of a toggle-encoded event line: sync, edge detect, saturating queue.
// Define TOGGLE_EVENT_RX_GLITCH_FILTER_EN to add a one-flop glitch filter.
module toggle_event_rx
  import toggle_rx_pkg::*;
#(
  parameter int SYNC_STAGES = TOGGLE_RX_SYNC_DEF,
  parameter int CNT_W       = TOGGLE_RX_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t_in,
  output logic             ev_pulse,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [CNT_W-1:0] pending,
  output logic             ovf,
  input  logic             ovf_clr
);

  logic sync_last;
  logic sync_out;
  logic prev;
  logic tog;
  logic pop;
  logic sat;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (t_in),
    .q   (sync_last)
  );

`ifdef TOGGLE_EVENT_RX_GLITCH_FILTER_EN
  logic filt;

  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= 1'b0;
    end else begin
      filt <= sync_last;
    end
  end

  // Level is accepted only once it has been stable for two samples;
  // otherwise the last accepted level is held.
  assign sync_out = (sync_last == filt) ? sync_last : prev;
`else
  assign sync_out = sync_last;
`endif

  // Handshake: an event transfers on any edge where ev_valid && ev_ready;
  // ev_valid never depends on ev_ready and stays high until all events pop.
  assign tog      = sync_out ^ prev;
  assign ev_valid = (pending != '0);
  assign pop      = ev_valid && ev_ready;
  assign sat      = (pending == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= 1'b0;
      ev_pulse <= 1'b0;
      pending  <= '0;
      ovf      <= 1'b0;
    end else begin
      prev     <= sync_out;
      ev_pulse <= tog;
      if (tog && !pop && !sat) begin
        pending <= pending + CNT_W'(1);
      end else if (!tog && pop) begin
        pending <= pending - CNT_W'(1);
      end
      // A dropped event outranks a simultaneous clear.
      if (tog && !pop && sat) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_toggle_event_rx.sv
// Self-checking bench for toggle_event_rx: directed scenarios plus random toggles,
// checked against an event-arrival model with saturating integer bookkeeping.
module tb_toggle_event_rx;
  import toggle_rx_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 4;
  localparam int MAXP        = (1 << CNT_W) - 1;
`ifdef TOGGLE_EVENT_RX_GLITCH_FILTER_EN
  localparam int LAT  = SYNC_STAGES + 1;
  localparam int MINH = 3;
`else
  localparam int LAT  = SYNC_STAGES;
  localparam int MINH = 2;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             t_in = 1'b0;
  logic             ev_ready = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             ev_pulse;
  logic             ev_valid;
  logic [CNT_W-1:0] pending;
  logic             ovf;

  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic        chk_en = 1'b0;
  logic [31:0] exp_q[$];
  int          m_pend = 0;
  logic        m_ovf = 1'b0;
  int          nxt;
  logic        tog_n;
  logic        pop_n;

  toggle_event_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .t_in     (t_in),
    .ev_pulse (ev_pulse),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .pending  (pending),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A level change after edge cyc reaches ev_pulse at edge cyc+1+LAT.
  task automatic toggle_line(input int hold);
    t_in = ~t_in;
    exp_q.push_back(32'(cyc + 1 + LAT));
    tick(hold);
  endtask

  task automatic reset_dut(input int n);
    rst = 1'b1;
    exp_q.delete();
    tick(1);
    chk_en = 1'b1;
    tick(n - 1);
    rst = 1'b0;
    // A high line at release looks like a toggle from the reset level 0.
    if (t_in) exp_q.push_back(32'(cyc + 1 + LAT));
  endtask

  // ---------------- monitor / scoreboard / model ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      if (ev_pulse === 1'b1) begin
        n_chk++;
        if (exp_q.size() > 0 && exp_q[0] == 32'(cyc)) begin
          n_pass++;
          void'(exp_q.pop_front());
        end else begin
          $display("FAIL ev_pulse cyc=%0d got=unexpected_pulse exp=%0d",
                   cyc, (exp_q.size() > 0) ? exp_q[0] : 0);
        end
      end else if (exp_q.size() > 0 && exp_q[0] <= 32'(cyc)) begin
        n_chk++;
        $display("FAIL ev_pulse cyc=%0d got=%b exp_pulse_at=%0d", cyc, ev_pulse, exp_q[0]);
        void'(exp_q.pop_front());
      end
      n_chk++;
      if (pending === pending_t'(m_pend)) n_pass++;
      else $display("FAIL pending cyc=%0d got=%0d exp=%0d", cyc, pending, m_pend);
      n_chk++;
      if (ev_valid === (m_pend > 0)) n_pass++;
      else $display("FAIL ev_valid cyc=%0d got=%b exp=%b", cyc, ev_valid, m_pend > 0);
      n_chk++;
      if (ovf === m_ovf) n_pass++;
      else $display("FAIL ovf cyc=%0d got=%b exp=%b", cyc, ovf, m_ovf);
    end
    // Predict state after the next edge from the inputs now stable.
    tog_n = (exp_q.size() > 0 && exp_q[0] == 32'(cyc + 1));
    pop_n = (m_pend > 0) && ev_ready;
    if (rst) begin
      m_pend = 0;
      m_ovf  = 1'b0;
    end else begin
      nxt = m_pend + int'(tog_n) - int'(pop_n);
      if (nxt > MAXP) begin
        m_pend = MAXP;
        m_ovf  = 1'b1;
      end else begin
        m_pend = nxt;
        if (ovf_clr) m_ovf = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_dut(3);
    tick(10);

    // single toggle, consumer stalled
    toggle_line(LAT + 3);
    // four more, spaced 3 cycles
    for (int i = 0; i < 4; i++) toggle_line(3);
    tick(LAT + 1);
    ev_ready = 1'b1;
    tick(8);
    ev_ready = 1'b0;

    // saturate and check sticky overflow, then clear it
    for (int i = 0; i < MAXP + 2; i++) toggle_line(MINH);
    tick(LAT + 2);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    tick(2);
    ev_ready = 1'b1;
    tick(MAXP + 2);
    ev_ready = 1'b0;

    // detection coinciding with a pop at pending=2, then reset mid-operation
    toggle_line(MINH);
    toggle_line(LAT + 2);
    t_in = ~t_in;
    exp_q.push_back(32'(cyc + 1 + LAT));
    tick(LAT);
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
    tick(MINH + 1);
    reset_dut(2);
    tick(LAT + 4);

`ifdef TOGGLE_EVENT_RX_GLITCH_FILTER_EN
    // single-cycle glitch must be rejected
    if (t_in) begin
      toggle_line(MINH + 2);
    end
    t_in = 1'b1;
    tick(1);
    t_in = 1'b0;
    tick(6);
    toggle_line(LAT + 2);
`endif

    // randomized toggles, ready and clear
    for (int i = 0; i < 120; i++) begin
      int hold;
      hold = $urandom_range(MINH, MINH + 3);
      t_in = ~t_in;
      exp_q.push_back(32'(cyc + 1 + LAT));
      for (int k = 0; k < hold; k++) begin
        ev_ready = (i < 60) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
        ovf_clr  = ($urandom_range(0, 15) == 0);
        tick(1);
      end
    end
    ev_ready = 1'b1;
    ovf_clr  = 1'b0;
    tick(MAXP + LAT + 6);

    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain got=%0d_outstanding exp=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
